issue_scheduler: RTL and testbench

//  Oldest-first issue scheduler between the reservation station and the functional units.

---
 rtl/issue_scheduler_if.sv | 54 +++++
 rtl/issue_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_issue_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_if.sv
// Issue scheduler bus: reservation-station/dispatch inputs and per-port issue outputs.
interface issue_scheduler_if #(
  parameter int unsigned RS_SIZE = 16
) ();
  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned FT_W  = 3;

  // Flush and dispatch allocation
  logic                    squash;
  logic                    alloc_en;
  logic [IDX_W-1:0]        alloc_idx;

  // Reservation station state
  logic [RS_SIZE-1:0]      entry_valid;
  logic [RS_SIZE-1:0]      entry_ready;
  logic [RS_SIZE*FT_W-1:0] entry_ftype;

  // Memory port back-pressure
  logic                    mem_ready;

  // Issue ports
  logic                    alu_issue_valid;
  logic [IDX_W-1:0]        alu_issue_idx;
  logic                    mult_issue_valid;
  logic [IDX_W-1:0]        mult_issue_idx;
  logic                    mem_issue_valid;
  logic [IDX_W-1:0]        mem_issue_idx;
  logic                    mem_issue_store;
  logic                    br_issue_valid;
  logic [IDX_W-1:0]        br_issue_idx;
  logic                    mult_busy;

  // Reservation station / dispatch side
  modport master (
    output squash, alloc_en, alloc_idx,
    output entry_valid, entry_ready, entry_ftype, mem_ready,
    input  alu_issue_valid, alu_issue_idx,
    input  mult_issue_valid, mult_issue_idx,
    input  mem_issue_valid, mem_issue_idx, mem_issue_store,
    input  br_issue_valid, br_issue_idx,
    input  mult_busy
  );

  // Scheduler side
  modport slave (
    input  squash, alloc_en, alloc_idx,
    input  entry_valid, entry_ready, entry_ftype, mem_ready,
    output alu_issue_valid, alu_issue_idx,
    output mult_issue_valid, mult_issue_idx,
    output mem_issue_valid, mem_issue_idx, mem_issue_store,
    output br_issue_valid, br_issue_idx,
    output mult_busy
  );
endinterface

// File: rtl/issue_scheduler.sv
// Oldest-first issue scheduler: one pick per port (ALU, MULT, MEM, BRANCH) per cycle,
// age tracked by an allocation-ordered age matrix, non-pipelined multiplier spacing
// enforced by a busy counter, MEM picks gated by the memory port's ready.
module issue_scheduler #(
  parameter int unsigned RS_SIZE      = 16,
  parameter int unsigned MULT_LATENCY = 4
) (
  input  logic             clock,
  input  logic             reset,
  issue_scheduler_if.slave sif
);
  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned FT_W  = 3;
  localparam int unsigned CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  localparam logic [FT_W-1:0] FT_ALU    = 3'd0;
  localparam logic [FT_W-1:0] FT_MULT   = 3'd1;
  localparam logic [FT_W-1:0] FT_LOAD   = 3'd2;
  localparam logic [FT_W-1:0] FT_STORE  = 3'd3;
  localparam logic [FT_W-1:0] FT_BRANCH = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

  // older_q[i][j] = 1: entry j was allocated before entry i
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q, older_d;
  logic [RS_SIZE-1:0]              issued_q, issued_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic                            alu_valid_q, alu_valid_d;
  logic [IDX_W-1:0]                alu_idx_q, alu_idx_d;
  logic                            mult_valid_q, mult_valid_d;
  logic [IDX_W-1:0]                mult_idx_q, mult_idx_d;
  logic                            mem_valid_q, mem_valid_d;
  logic [IDX_W-1:0]                mem_idx_q, mem_idx_d;
  logic                            mem_store_q, mem_store_d;
  logic                            br_valid_q, br_valid_d;
  logic [IDX_W-1:0]                br_idx_q, br_idx_d;
  logic                            mult_busy_q, mult_busy_d;

  logic [RS_SIZE-1:0] alloc_oh;
  logic [RS_SIZE-1:0] cls_alu, cls_mult, cls_mem, cls_br, cls_store;
  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0] cand_alu, cand_mult, cand_mem, cand_br;
  logic [RS_SIZE-1:0] pick_alu, pick_mult, pick_mem, pick_br;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [RS_SIZE-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Decode each entry's function type into its issue-port class
  always_comb begin
    cls_alu   = '0;
    cls_mult  = '0;
    cls_mem   = '0;
    cls_br    = '0;
    cls_store = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      case (sif.entry_ftype[i*FT_W +: FT_W])
        FT_ALU:    cls_alu[i]  = 1'b1;
        FT_MULT:   cls_mult[i] = 1'b1;
        FT_LOAD:   cls_mem[i]  = 1'b1;
        FT_STORE: begin
          cls_mem[i]   = 1'b1;
          cls_store[i] = 1'b1;
        end
        FT_BRANCH: cls_br[i]   = 1'b1;
        default:   ;
      endcase
    end
  end

  // Candidate masks per port, including multiplier and memory-port gating
  always_comb begin
    alloc_oh = '0;
    if (sif.alloc_en) alloc_oh[sif.alloc_idx] = 1'b1;
    // An entry being written this cycle is never a candidate, and a just-issued entry
    // is hidden for the one cycle the RS needs to clear it.
    cand      = sif.entry_valid & sif.entry_ready & ~issued_q & ~alloc_oh;
    cand_alu  = cand & cls_alu;
    cand_mult = (cnt_q == '0) ? (cand & cls_mult) : '0;
    cand_mem  = sif.mem_ready ? (cand & cls_mem) : '0;
    cand_br   = cand & cls_br;
  end

  // Oldest-first pick: a candidate wins when no older candidate shares its class
  always_comb begin
    pick_alu  = '0;
    pick_mult = '0;
    pick_mem  = '0;
    pick_br   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      pick_alu[i]  = cand_alu[i]  & ~(|(older_q[i] & cand_alu));
      pick_mult[i] = cand_mult[i] & ~(|(older_q[i] & cand_mult));
      pick_mem[i]  = cand_mem[i]  & ~(|(older_q[i] & cand_mem));
      pick_br[i]   = cand_br[i]   & ~(|(older_q[i] & cand_br));
    end
  end

  // Age matrix: a new entry is younger than everything currently valid
  always_comb begin
    older_d = older_q;
    if (sif.alloc_en) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        older_d[i][sif.alloc_idx] = 1'b0;
      end
      older_d[sif.alloc_idx] = sif.entry_valid & ~alloc_oh;
    end
  end

  // Issue outputs, issued mask and multiplier occupancy; squash discards this cycle's picks
  always_comb begin
    alu_valid_d  = |pick_alu;
    alu_idx_d    = onehot_to_idx(pick_alu);
    mult_valid_d = |pick_mult;
    mult_idx_d   = onehot_to_idx(pick_mult);
    mem_valid_d  = |pick_mem;
    mem_idx_d    = onehot_to_idx(pick_mem);
    mem_store_d  = |(pick_mem & cls_store);
    br_valid_d   = |pick_br;
    br_idx_d     = onehot_to_idx(pick_br);
    issued_d     = pick_alu | pick_mult | pick_mem | pick_br;

    cnt_d = cnt_q;
    if (|pick_mult)        cnt_d = CNT_LOAD;
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);

    // Busy covers the issue cycle plus the remaining counted occupancy
    mult_busy_d = (|pick_mult) | (cnt_q != '0);

    if (sif.squash) begin
      alu_valid_d  = 1'b0;
      alu_idx_d    = '0;
      mult_valid_d = 1'b0;
      mult_idx_d   = '0;
      mem_valid_d  = 1'b0;
      mem_idx_d    = '0;
      mem_store_d  = 1'b0;
      br_valid_d   = 1'b0;
      br_idx_d     = '0;
      issued_d     = '0;
      cnt_d        = '0;
      mult_busy_d  = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      older_q      <= '0;
      issued_q     <= '0;
      cnt_q        <= '0;
      alu_valid_q  <= 1'b0;
      alu_idx_q    <= '0;
      mult_valid_q <= 1'b0;
      mult_idx_q   <= '0;
      mem_valid_q  <= 1'b0;
      mem_idx_q    <= '0;
      mem_store_q  <= 1'b0;
      br_valid_q   <= 1'b0;
      br_idx_q     <= '0;
      mult_busy_q  <= 1'b0;
    end else begin
      older_q      <= older_d;
      issued_q     <= issued_d;
      cnt_q        <= cnt_d;
      alu_valid_q  <= alu_valid_d;
      alu_idx_q    <= alu_idx_d;
      mult_valid_q <= mult_valid_d;
      mult_idx_q   <= mult_idx_d;
      mem_valid_q  <= mem_valid_d;
      mem_idx_q    <= mem_idx_d;
      mem_store_q  <= mem_store_d;
      br_valid_q   <= br_valid_d;
      br_idx_q     <= br_idx_d;
      mult_busy_q  <= mult_busy_d;
    end
  end

  assign sif.alu_issue_valid  = alu_valid_q;
  assign sif.alu_issue_idx    = alu_idx_q;
  assign sif.mult_issue_valid = mult_valid_q;
  assign sif.mult_issue_idx   = mult_idx_q;
  assign sif.mem_issue_valid  = mem_valid_q;
  assign sif.mem_issue_idx    = mem_idx_q;
  assign sif.mem_issue_store  = mem_store_q;
  assign sif.br_issue_valid   = br_valid_q;
  assign sif.br_issue_idx     = br_idx_q;
  assign sif.mult_busy        = mult_busy_q;

  // Dispatch must never overwrite an occupied entry
  a_alloc_free: assert property (@(posedge clock) disable iff (reset)
    sif.alloc_en |-> !sif.entry_valid[sif.alloc_idx]);

  // The age matrix must yield at most one winner per port
  a_pick_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(pick_alu) && $onehot0(pick_mult) && $onehot0(pick_mem) && $onehot0(pick_br));
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: each driven cycle pushes the expected issue-port
// state for the following cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_issue_scheduler;
  localparam int unsigned RS = 16;
  localparam logic [2:0] ALU = 3'd0, MUL = 3'd1, LD = 3'd2, ST = 3'd3, BR = 3'd4;

  typedef struct packed {
    logic       alu_v;  logic [3:0] alu_i;
    logic       mul_v;  logic [3:0] mul_i;
    logic       mem_v;  logic       mem_st; logic [3:0] mem_i;
    logic       br_v;   logic [3:0] br_i;
    logic       busy;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t e;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_scheduler_if #(.RS_SIZE(RS)) sif ();
  issue_scheduler #(.RS_SIZE(RS), .MULT_LATENCY(4)) dut (.clock(clk), .reset(rst), .sif(sif));

  // RS model driven by the bench
  logic          sq, aen, mrdy;
  logic [3:0]    aidx;
  logic [RS-1:0] v, rdy;
  logic [2:0]    ft [RS];
  logic [RS*3-1:0] ftf;

  always_comb begin
    ftf = '0;
    for (int i = 0; i < RS; i++) ftf[i*3 +: 3] = ft[i];
  end

  assign sif.squash      = sq;
  assign sif.alloc_en    = aen;
  assign sif.alloc_idx   = aidx;
  assign sif.entry_valid = v;
  assign sif.entry_ready = rdy;
  assign sif.entry_ftype = ftf;
  assign sif.mem_ready   = mrdy;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc_cnt  = 0;
  sb_t  sb_q[$];
  exp_t nxt;
  logic [RS-1:0] pend1, pend2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RS-1:0] issued_of(input exp_t e);
    logic [RS-1:0] m;
    m = '0;
    if (e.alu_v) m[e.alu_i] = 1'b1;
    if (e.mul_v) m[e.mul_i] = 1'b1;
    if (e.mem_v) m[e.mem_i] = 1'b1;
    if (e.br_v)  m[e.br_i]  = 1'b1;
    return m;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare outputs against the expectation scheduled for this cycle
  always @(negedge clk) begin : mon
    sb_t it;
    while (sb_q.size() != 0 && sb_q[0].cyc == cyc_cnt) begin
      it = sb_q.pop_front();
      check_eq($sformatf("alu@%0d", it.cyc),
               32'({sif.alu_issue_valid, sif.alu_issue_idx}), 32'({it.e.alu_v, it.e.alu_i}));
      check_eq($sformatf("mult@%0d", it.cyc),
               32'({sif.mult_issue_valid, sif.mult_issue_idx}), 32'({it.e.mul_v, it.e.mul_i}));
      check_eq($sformatf("mem@%0d", it.cyc),
               32'({sif.mem_issue_valid, sif.mem_issue_store, sif.mem_issue_idx}),
               32'({it.e.mem_v, it.e.mem_st, it.e.mem_i}));
      check_eq($sformatf("br@%0d", it.cyc),
               32'({sif.br_issue_valid, sif.br_issue_idx}), 32'({it.e.br_v, it.e.br_i}));
      check_eq($sformatf("busy@%0d", it.cyc), 32'(sif.mult_busy), 32'(it.e.busy));
    end
  end

  // One driven cycle: schedule nxt for the next cycle; RS clears issued entries a cycle
  // after they appear on the issue port
  task automatic cycle();
    sb_t it;
    it.cyc = cyc_cnt + 1;
    it.e   = nxt;
    sb_q.push_back(it);
    pend2 = pend1;
    pend1 = issued_of(nxt);
    nxt   = '0;
    @(negedge clk);
    v = v & ~pend2;
  endtask

  task automatic alloc(input int idx, input logic [2:0] f);
    aen   = 1'b1;
    aidx  = 4'(idx);
    ft[idx] = f;
    cycle();
    aen   = 1'b0;
    v[idx] = 1'b1;
  endtask

  task automatic busy_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      nxt.busy = 1'b1;
      cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sq = 1'b0; aen = 1'b0; aidx = '0; mrdy = 1'b1;
    v = '0; rdy = '0; nxt = '0; pend1 = '0; pend2 = '0;
    for (int i = 0; i < RS; i++) ft[i] = ALU;
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Reset while a mult is in flight and outputs are valid
    ft[1] = MUL; ft[2] = ALU; v[1] = 1'b1; v[2] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;
    nxt.mul_v = 1'b1; nxt.mul_i = 4'd1; nxt.alu_v = 1'b1; nxt.alu_i = 4'd2; nxt.busy = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; rdy = '0;
    cycle();
    cycle();

    // ALU age order 5, 2, 9
    alloc(5, ALU); alloc(2, ALU); alloc(9, ALU);
    rdy[5] = 1'b1; rdy[2] = 1'b1; rdy[9] = 1'b1;
    nxt.alu_v = 1'b1; nxt.alu_i = 4'd5; cycle();
    nxt.alu_v = 1'b1; nxt.alu_i = 4'd2; cycle();
    nxt.alu_v = 1'b1; nxt.alu_i = 4'd9; cycle();
    cycle(); cycle();
    rdy = '0;

    // Multiplier spacing: 1 then 3 four cycles later
    alloc(1, MUL); alloc(3, MUL);
    rdy[1] = 1'b1; rdy[3] = 1'b1;
    nxt.mul_v = 1'b1; nxt.mul_i = 4'd1; nxt.busy = 1'b1; cycle();
    busy_cycles(3);
    nxt.mul_v = 1'b1; nxt.mul_i = 4'd3; nxt.busy = 1'b1; cycle();
    busy_cycles(3);
    cycle(); cycle();
    rdy = '0;

    // Memory port: older load 7 then store 4, held off by mem_ready
    alloc(7, LD); alloc(4, ST);
    rdy[7] = 1'b1; rdy[4] = 1'b1; mrdy = 1'b0;
    cycle(); cycle();
    mrdy = 1'b1;
    nxt.mem_v = 1'b1; nxt.mem_st = 1'b0; nxt.mem_i = 4'd7; cycle();
    nxt.mem_v = 1'b1; nxt.mem_st = 1'b1; nxt.mem_i = 4'd4; cycle();
    cycle(); cycle();
    rdy = '0;

    // Squash after a mult pick: in-flight mult and squash-cycle picks dropped
    alloc(6, MUL); alloc(8, MUL); alloc(10, ALU);
    rdy[6] = 1'b1;
    nxt.mul_v = 1'b1; nxt.mul_i = 4'd6; nxt.busy = 1'b1; cycle();
    sq = 1'b1; rdy[8] = 1'b1; rdy[10] = 1'b1;
    cycle();
    sq = 1'b0; v[6] = 1'b0; v[10] = 1'b0;
    nxt.mul_v = 1'b1; nxt.mul_i = 4'd8; nxt.busy = 1'b1; cycle();
    busy_cycles(3);
    cycle(); cycle();
    rdy = '0;

    // All four ports in the same cycle
    alloc(0, ALU); alloc(11, MUL); alloc(13, ST); alloc(14, BR);
    rdy[0] = 1'b1; rdy[11] = 1'b1; rdy[13] = 1'b1; rdy[14] = 1'b1;
    nxt.alu_v = 1'b1; nxt.alu_i = 4'd0;
    nxt.mul_v = 1'b1; nxt.mul_i = 4'd11; nxt.busy = 1'b1;
    nxt.mem_v = 1'b1; nxt.mem_st = 1'b1; nxt.mem_i = 4'd13;
    nxt.br_v  = 1'b1; nxt.br_i  = 4'd14;
    cycle();
    busy_cycles(3);
    cycle(); cycle();
    rdy = '0;

    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
